// File: rtl/srgh_pkg.sv
// rtl/srgh_pkg.sv - shared tick constants and boot sequencer state encodings
package srgh_pkg;

    localparam int unsigned TICK_NS = 2500;

    // Must match the I2C sender: one 256-bit message plus margin
    localparam int unsigned SENDER_MSG_TICKS = 288;

    function automatic int unsigned ns_to_ticks(input int unsigned ns);
        return ns / TICK_NS;
    endfunction

    localparam int unsigned POST_TIMEOUT_TICKS = ns_to_ticks(500_000_000);
    localparam int unsigned CPU_RST_TICKS      = ns_to_ticks(100_000);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARMED = 3'd1;
    localparam state_t ST_SLOW  = 3'd2;
    localparam state_t ST_FAST  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
    localparam state_t ST_RESET = 3'd5;
    localparam state_t ST_HALT  = 3'd6;

endpackage

// File: rtl/post_edge_sync.sv
// rtl/post_edge_sync.sv - 2-FF synchroniser with a one-cycle change pulse
module post_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic change
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level  = s2;
    assign change = s2 ^ s3;

endmodule

// File: rtl/post_glitch_ctrl.sv
// rtl/post_glitch_ctrl.sv - POST-driven slowdown/speedup sequencer; RETRY_LIMIT_EN adds HALT after repeated failures
module post_glitch_ctrl
    import srgh_pkg::*;
#(
    parameter int unsigned SLOW_EDGE     = 3,
    parameter int unsigned FAST_EDGE     = 2,
    parameter int unsigned MSG_TICKS     = SENDER_MSG_TICKS,
    parameter int unsigned TIMEOUT_TICKS = POST_TIMEOUT_TICKS,
    parameter int unsigned RST_TICKS     = CPU_RST_TICKS
`ifdef RETRY_LIMIT_EN
    ,
    parameter int unsigned MAX_RETRIES   = 15
`endif
) (
    input  logic       clk_400k,
    input  logic       rst,
    input  logic       post_bit,
    input  logic       cpu_rst_n,
    output logic       i2c_send,
    output logic       cpu_rst_req,
    output logic       boot_ok,
    output logic       glitch_busy,
    output logic [7:0] attempts,
    output logic       fail
);

    localparam logic [17:0] TMR_MAX   = '1;
    localparam logic [17:0] TMO_LAST  = 18'(TIMEOUT_TICKS - 1);
    localparam logic [17:0] HOLD_LAST = 18'(MSG_TICKS - 1);
    localparam logic [17:0] RST_LAST  = 18'(RST_TICKS - 1);
    localparam logic [3:0]  SLOW_LAST = 4'(SLOW_EDGE - 1);
    localparam logic [3:0]  FAST_CNT  = 4'(FAST_EDGE);

    logic   post_lvl, post_edge, rst_n_s, rst_n_chg;
    logic   unused_sync;
    state_t state, nxt;
    logic   timeout;
    logic [17:0] tmr, tmr_hold;
    logic [3:0]  ecnt;

    post_edge_sync u_post_sync (
        .clk    (clk_400k),
        .rst    (rst),
        .din    (post_bit),
        .level  (post_lvl),
        .change (post_edge)
    );

    post_edge_sync u_rst_sync (
        .clk    (clk_400k),
        .rst    (rst),
        .din    (cpu_rst_n),
        .level  (rst_n_s),
        .change (rst_n_chg)
    );

    assign unused_sync = post_lvl ^ rst_n_chg;

`ifdef RETRY_LIMIT_EN
    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRIES);
    logic [3:0] cfail;
`endif

    // Hold counts completed cycles from 0, so HOLD_LAST gives exactly MSG_TICKS cycles per level
    always_comb begin
        nxt     = state;
        timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n_s) nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!rst_n_s) nxt = ST_IDLE;
                else if (post_edge && ecnt == SLOW_LAST) nxt = ST_SLOW;
            end
            ST_SLOW: begin
                if (!rst_n_s) nxt = ST_IDLE;
                else if (ecnt >= FAST_CNT && tmr_hold >= HOLD_LAST) nxt = ST_FAST;
                else if (!post_edge && tmr == TMO_LAST) begin
                    nxt     = ST_RESET;
                    timeout = 1'b1;
                end
            end
            ST_FAST: begin
                // ecnt != 0 remembers an edge that arrived before the hold expired
                if (!rst_n_s) nxt = ST_IDLE;
                else if ((post_edge || ecnt != 4'd0) && tmr_hold >= HOLD_LAST) nxt = ST_DONE;
                else if (!post_edge && tmr == TMO_LAST) begin
                    nxt     = ST_RESET;
                    timeout = 1'b1;
                end
            end
            ST_DONE: begin
                if (!rst_n_s) nxt = ST_IDLE;
            end
            ST_RESET: begin
`ifdef RETRY_LIMIT_EN
                if (tmr == RST_LAST) nxt = (cfail >= RETRY_LAST) ? ST_HALT : ST_IDLE;
`else
                if (tmr == RST_LAST) nxt = ST_IDLE;
`endif
            end
            default: nxt = state;
        endcase
    end

    always_ff @(posedge clk_400k) begin
        if (rst) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            tmr_hold    <= '0;
            ecnt        <= '0;
            i2c_send    <= 1'b0;
            cpu_rst_req <= 1'b0;
            boot_ok     <= 1'b0;
            glitch_busy <= 1'b0;
            attempts    <= '0;
            fail        <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                tmr      <= '0;
                tmr_hold <= '0;
                ecnt     <= '0;
            end else begin
                if (post_edge) tmr <= '0;
                else if (tmr != TMR_MAX) tmr <= tmr + 18'd1;
                if (tmr_hold != TMR_MAX) tmr_hold <= tmr_hold + 18'd1;
                if (post_edge && ecnt != 4'hf) ecnt <= ecnt + 4'd1;
            end
            // Outputs are registered decodes of the next state so they change with the transition
            i2c_send    <= (nxt == ST_SLOW);
            cpu_rst_req <= (nxt == ST_RESET);
            boot_ok     <= (nxt == ST_DONE);
            glitch_busy <= (nxt == ST_SLOW) || (nxt == ST_FAST);
`ifdef RETRY_LIMIT_EN
            fail        <= (nxt == ST_HALT);
`else
            fail        <= 1'b0;
`endif
            if (timeout && attempts != 8'hff) attempts <= attempts + 8'd1;
        end
    end

`ifdef RETRY_LIMIT_EN
    always_ff @(posedge clk_400k) begin
        if (rst) begin
            cfail <= '0;
        end else if (nxt == ST_DONE && state != ST_DONE) begin
            cfail <= '0;
        end else if (timeout && cfail != 4'hf) begin
            cfail <= cfail + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_post_glitch_ctrl.sv
// tb/tb_post_glitch_ctrl.sv - directed bench for post_glitch_ctrl
module tb_post_glitch_ctrl;

    logic       clk_400k = 1'b0;
    logic       rst;
    logic       post_bit;
    logic       cpu_rst_n;
    logic       i2c_send;
    logic       cpu_rst_req;
    logic       boot_ok;
    logic       glitch_busy;
    logic [7:0] attempts;
    logic       fail;

    int errors = 0;
    int checks = 0;

    always #5 clk_400k = ~clk_400k;

    post_glitch_ctrl #(
        .TIMEOUT_TICKS (1000),
        .MSG_TICKS     (288),
        .RST_TICKS     (40)
`ifdef RETRY_LIMIT_EN
        ,
        .MAX_RETRIES   (3)
`endif
    ) dut (
        .clk_400k    (clk_400k),
        .rst         (rst),
        .post_bit    (post_bit),
        .cpu_rst_n   (cpu_rst_n),
        .i2c_send    (i2c_send),
        .cpu_rst_req (cpu_rst_req),
        .boot_ok     (boot_ok),
        .glitch_busy (glitch_busy),
        .attempts    (attempts),
        .fail        (fail)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_400k);
    endtask

    // Three POST edges from ARMED; slowdown must appear on the third clock after the last pin change
    task automatic arm_to_slow(input int gap);
        post_bit = ~post_bit;
        step(gap);
        post_bit = ~post_bit;
        step(gap);
        post_bit = ~post_bit;
        step(2);
        check("pre_rise", 32'(i2c_send), 0);
        step(1);
        check("slow_rise", 32'(i2c_send), 1);
        check("slow_busy", 32'(glitch_busy), 1);
    endtask

    initial begin
        rst       = 1'b1;
        post_bit  = 1'b0;
        cpu_rst_n = 1'b1;
        step(3);
        check("rst_i2c", 32'(i2c_send), 0);
        check("rst_req", 32'(cpu_rst_req), 0);
        check("rst_ok", 32'(boot_ok), 0);
        check("rst_busy", 32'(glitch_busy), 0);
        check("rst_att", 32'(attempts), 0);
        check("rst_fail", 32'(fail), 0);
        rst = 1'b0;
        step(5);

        // Good boot, POST toggling every 100 ticks
        arm_to_slow(100);
        step(97);
        post_bit = ~post_bit;
        step(100);
        post_bit = ~post_bit;
        step(90);
        check("good_hold", 32'(i2c_send), 1);
        step(1);
        check("good_fall", 32'(i2c_send), 0);
        check("good_fast_busy", 32'(glitch_busy), 1);
        step(9);
        post_bit = ~post_bit;
        step(100);
        post_bit = ~post_bit;
        step(100);
        post_bit = ~post_bit;
        step(78);
        check("good_pre_done", 32'(boot_ok), 0);
        step(1);
        check("good_done", 32'(boot_ok), 1);
        check("good_done_busy", 32'(glitch_busy), 0);
        check("good_done_i2c", 32'(i2c_send), 0);
        check("good_att", 32'(attempts), 0);
        cpu_rst_n = 1'b0;
        step(3);
        check("done_exit_ok", 32'(boot_ok), 0);
        cpu_rst_n = 1'b1;
        step(10);

        // Fast edges right after slowdown: level still held for 288 ticks
        arm_to_slow(10);
        step(7);
        post_bit = ~post_bit;
        step(20);
        post_bit = ~post_bit;
        step(260);
        check("fast_hold", 32'(i2c_send), 1);
        step(1);
        check("fast_fall", 32'(i2c_send), 0);
        cpu_rst_n = 1'b0;
        step(2);
        check("fast_force_pre", 32'(glitch_busy), 1);
        step(1);
        check("fast_force", 32'(glitch_busy), 0);
        cpu_rst_n = 1'b1;
        step(10);

        // External reset mid-SLOW drops the request at once
        arm_to_slow(10);
        step(50);
        cpu_rst_n = 1'b0;
        step(2);
        check("ext_pre", 32'(i2c_send), 1);
        step(1);
        check("ext_i2c", 32'(i2c_send), 0);
        check("ext_att", 32'(attempts), 0);
        check("ext_req", 32'(cpu_rst_req), 0);
        cpu_rst_n = 1'b1;
        step(10);

        // Timeout, with cpu_rst_n pulled low during RESET
        arm_to_slow(10);
        step(999);
        check("tmo_pre_i2c", 32'(i2c_send), 1);
        check("tmo_pre_req", 32'(cpu_rst_req), 0);
        step(1);
        check("tmo_i2c", 32'(i2c_send), 0);
        check("tmo_req", 32'(cpu_rst_req), 1);
        check("tmo_att", 32'(attempts), 1);
        check("tmo_busy", 32'(glitch_busy), 0);
        step(5);
        cpu_rst_n = 1'b0;
        step(34);
        check("tmo_req_last", 32'(cpu_rst_req), 1);
        step(1);
        check("tmo_req_end", 32'(cpu_rst_req), 0);
        cpu_rst_n = 1'b1;
        step(10);

        // Edge on the same cycle as the timeout wins and restarts the timer
        arm_to_slow(10);
        step(997);
        post_bit = ~post_bit;
        step(3);
        check("tie_i2c", 32'(i2c_send), 1);
        check("tie_req", 32'(cpu_rst_req), 0);
        check("tie_att", 32'(attempts), 1);
        step(999);
        check("tie_late_i2c", 32'(i2c_send), 1);
        step(1);
        check("tie_late_req", 32'(cpu_rst_req), 1);
        check("tie_late_att", 32'(attempts), 2);
        step(40);
        check("tie_req_end", 32'(cpu_rst_req), 0);
        step(5);

        // Third consecutive failure
        arm_to_slow(10);
        step(1000);
        check("lim_att", 32'(attempts), 3);
        check("lim_req", 32'(cpu_rst_req), 1);
        step(40);
        check("lim_req_end", 32'(cpu_rst_req), 0);
`ifdef RETRY_LIMIT_EN
        check("lim_fail", 32'(fail), 1);
        post_bit = ~post_bit;
        step(10);
        post_bit = ~post_bit;
        step(10);
        post_bit = ~post_bit;
        cpu_rst_n = 1'b0;
        step(10);
        cpu_rst_n = 1'b1;
        step(10);
        check("halt_i2c", 32'(i2c_send), 0);
        check("halt_busy", 32'(glitch_busy), 0);
        step(1100);
        check("halt_req", 32'(cpu_rst_req), 0);
        check("halt_fail", 32'(fail), 1);
        rst = 1'b1;
        step(2);
        check("halt_rst_fail", 32'(fail), 0);
        check("halt_rst_att", 32'(attempts), 0);
        rst = 1'b0;
`else
        check("nolim_fail", 32'(fail), 0);
        step(5);
        arm_to_slow(10);
        check("nolim_att", 32'(attempts), 3);
        check("nolim_fail2", 32'(fail), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
